exe_alu_fwd: RTL and testbench

Execute-stage datapath core. It selects each ALU operand from two priority-ordered bypass sources or the register-file value, then computes a 32-bit MIPS integer result. It also owns the architectural HI/LO registers used by multiply, divide and the move-to/from instructions. It sits between issue/register-read and the EXE pipeline register; the result is combinational and the caller registers it.

---
 rtl/exe_alu_fwd.sv | 112 +++++++++++
 tb/tb_exe_alu_fwd.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/exe_alu_fwd.sv
// Execute-stage ALU with two-level operand bypass and architectural HI/LO registers.
// Operand select and Result are combinational; only HI/LO are clocked.
module exe_alu_fwd (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        Valid,
  input  logic [4:0]  RegA,
  input  logic [31:0] DataA,
  input  logic [4:0]  RegB,
  input  logic [31:0] DataB,
  input  logic [4:0]  FwdReg1,
  input  logic [31:0] FwdData1,
  input  logic        FwdValid1,
  input  logic [4:0]  FwdReg2,
  input  logic [31:0] FwdData2,
  input  logic        FwdValid2,
  input  logic [5:0]  ALU_Control,
  input  logic [4:0]  ShiftAmount,
  output logic [31:0] A_Out,
  output logic [31:0] B_Out,
  output logic [31:0] Result,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [5:0] {
    OP_AND   = 6'h00, OP_OR    = 6'h01, OP_ADD   = 6'h02, OP_XOR   = 6'h03,
    OP_NOR   = 6'h04, OP_SUB   = 6'h06, OP_SLT   = 6'h07, OP_SLTU  = 6'h08,
    OP_ADDU  = 6'h09, OP_SUBU  = 6'h0A, OP_SLL   = 6'h0B, OP_SRL   = 6'h0C,
    OP_SRA   = 6'h0D, OP_SLLV  = 6'h0E, OP_SRLV  = 6'h0F, OP_SRAV  = 6'h10,
    OP_LUI   = 6'h11, OP_MULT  = 6'h12, OP_MULTU = 6'h13, OP_DIV   = 6'h14,
    OP_DIVU  = 6'h15, OP_MFHI  = 6'h16, OP_MFLO  = 6'h17, OP_MTHI  = 6'h18,
    OP_MTLO  = 6'h19, OP_PASSA = 6'h1A, OP_PASSB = 6'h1B
  } op_e;

  logic [31:0] a, b;
  logic [63:0] prod_s, prod_u;
  logic [31:0] ua, ub, ub_safe, uq, ur, sq, sr, dq, dr;
  logic        b_zero;

  always_comb begin
    a = DataA;
    if (FwdValid1 && FwdReg1 == RegA && RegA != 5'd0)      a = FwdData1;
    else if (FwdValid2 && FwdReg2 == RegA && RegA != 5'd0) a = FwdData2;
    b = DataB;
    if (FwdValid1 && FwdReg1 == RegB && RegB != 5'd0)      b = FwdData1;
    else if (FwdValid2 && FwdReg2 == RegB && RegB != 5'd0) b = FwdData2;
  end

  assign A_Out = a;
  assign B_Out = b;

  // Low 64 bits of the sign-extended product equal the true signed product.
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide via magnitudes; 0x80000000 / -1 naturally yields 0x80000000 rem 0.
  assign b_zero  = (b == '0);
  assign ua      = a[31] ? (~a + 32'd1) : a;
  assign ub      = b[31] ? (~b + 32'd1) : b;
  assign ub_safe = b_zero ? 32'd1 : ub;
  assign uq      = ua / ub_safe;
  assign ur      = ua % ub_safe;
  assign sq      = (a[31] ^ b[31]) ? (~uq + 32'd1) : uq;
  assign sr      = a[31] ? (~ur + 32'd1) : ur;
  assign dq      = a / (b_zero ? 32'd1 : b);
  assign dr      = a % (b_zero ? 32'd1 : b);

  always_comb begin
    Result = '0;
    case (ALU_Control)
      OP_AND:           Result = a & b;
      OP_OR:            Result = a | b;
      OP_XOR:           Result = a ^ b;
      OP_NOR:           Result = ~(a | b);
      OP_ADD, OP_ADDU:  Result = a + b;
      OP_SUB, OP_SUBU:  Result = a - b;
      OP_SLT:           Result = {31'd0, ($signed(a) < $signed(b))};
      OP_SLTU:          Result = {31'd0, (a < b)};
      OP_SLL:           Result = b << ShiftAmount;
      OP_SRL:           Result = b >> ShiftAmount;
      OP_SRA:           Result = $signed(b) >>> ShiftAmount;
      OP_SLLV:          Result = b << a[4:0];
      OP_SRLV:          Result = b >> a[4:0];
      OP_SRAV:          Result = $signed(b) >>> a[4:0];
      OP_LUI:           Result = {b[15:0], 16'h0000};
      OP_MFHI:          Result = HI;
      OP_MFLO:          Result = LO;
      OP_PASSA:         Result = a;
      OP_PASSB:         Result = b;
      default:          Result = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      HI <= '0;
      LO <= '0;
    end else if (Valid) begin
      case (ALU_Control)
        OP_MULT:  begin HI <= prod_s[63:32]; LO <= prod_s[31:0]; end
        OP_MULTU: begin HI <= prod_u[63:32]; LO <= prod_u[31:0]; end
        OP_DIV:   if (!b_zero) begin HI <= sr; LO <= sq; end
        OP_DIVU:  if (!b_zero) begin HI <= dr; LO <= dq; end
        OP_MTHI:  HI <= a;
        OP_MTLO:  LO <= a;
        default:  ;
      endcase
    end
  end

endmodule

// File: tb/tb_exe_alu_fwd.sv
// Directed self-checking bench for exe_alu_fwd: bypass, ALU ops, HI/LO writes and reset.
module tb_exe_alu_fwd;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        Valid;
  logic [4:0]  RegA, RegB, FwdReg1, FwdReg2, ShiftAmount;
  logic [31:0] DataA, DataB, FwdData1, FwdData2;
  logic        FwdValid1, FwdValid2;
  logic [5:0]  ALU_Control;
  logic [31:0] A_Out, B_Out, Result, HI, LO;

  int checks = 0;
  int errors = 0;

  exe_alu_fwd dut (
    .CLK(CLK), .RESET(RESET), .Valid(Valid),
    .RegA(RegA), .DataA(DataA), .RegB(RegB), .DataB(DataB),
    .FwdReg1(FwdReg1), .FwdData1(FwdData1), .FwdValid1(FwdValid1),
    .FwdReg2(FwdReg2), .FwdData2(FwdData2), .FwdValid2(FwdValid2),
    .ALU_Control(ALU_Control), .ShiftAmount(ShiftAmount),
    .A_Out(A_Out), .B_Out(B_Out), .Result(Result), .HI(HI), .LO(LO)
  );

  always #5 CLK = ~CLK;

  task automatic set_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    RegA = 5'd1; RegB = 5'd2; DataA = a; DataB = b;
    FwdValid1 = 1'b0; FwdValid2 = 1'b0; FwdReg1 = '0; FwdReg2 = '0;
    FwdData1 = '0; FwdData2 = '0; ALU_Control = op; ShiftAmount = '0;
  endtask

  task automatic test_reset;
    RESET = 1'b0; Valid = 1'b0;
    set_op(6'h00, 32'd0, 32'd0);
    #12;
    checks++;
    if (HI !== 32'd0 || LO !== 32'd0) begin
      errors++; $display("FAIL reset_hilo HI=%h LO=%h required 0/0", HI, LO);
    end
    @(negedge CLK) RESET = 1'b1;
  endtask

  task automatic test_bypass;
    @(negedge CLK);
    set_op(6'h1A, 32'd1, 32'd9);
    RegA = 5'd5; FwdReg1 = 5'd5; FwdData1 = 32'hAA; FwdValid1 = 1'b1;
    FwdReg2 = 5'd5; FwdData2 = 32'hBB; FwdValid2 = 1'b1;
    #1; checks++;
    if (A_Out !== 32'hAA) begin errors++; $display("FAIL byp_fwd1 A_Out=%h required 000000aa", A_Out); end
    FwdValid1 = 1'b0; #1; checks++;
    if (A_Out !== 32'hBB) begin errors++; $display("FAIL byp_fwd2 A_Out=%h required 000000bb", A_Out); end
    FwdValid1 = 1'b1; RegA = 5'd0; FwdReg1 = 5'd0; FwdReg2 = 5'd0; #1; checks++;
    if (A_Out !== 32'd1) begin errors++; $display("FAIL byp_r0 A_Out=%h required 00000001", A_Out); end
    // B side: Fwd1 misses, Fwd2 hits
    RegB = 5'd3; FwdReg1 = 5'd4; FwdReg2 = 5'd3; #1; checks++;
    if (B_Out !== 32'hBB) begin errors++; $display("FAIL byp_b B_Out=%h required 000000bb", B_Out); end
    ALU_Control = 6'h1B; #1; checks++;
    if (Result !== 32'hBB) begin errors++; $display("FAIL byp_passb Result=%h required 000000bb", Result); end
  endtask

  task automatic test_arith;
    logic [5:0]  ops [11];
    logic [31:0] as  [11];
    logic [31:0] bs  [11];
    logic [31:0] exp [11];
    ops = '{6'h02, 6'h06, 6'h07, 6'h08, 6'h00, 6'h01, 6'h03, 6'h04, 6'h11, 6'h09, 6'h3F};
    as  = '{32'h7FFFFFFF, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hF0F0, 32'hF0F0, 32'hF0F0,
            32'hF0F0, 32'd0, 32'hFFFFFFFF, 32'h1234};
    bs  = '{32'd1, 32'd1, 32'd1, 32'd1, 32'hFF00, 32'hFF00, 32'hFF00, 32'hFF00,
            32'hABCD1234, 32'd2, 32'h5678};
    exp = '{32'h80000000, 32'hFFFFFFFF, 32'd1, 32'd0, 32'hF000, 32'hFFF0, 32'h0FF0,
            32'hFFFF000F, 32'h12340000, 32'd1, 32'd0};
    for (int i = 0; i < 11; i++) begin
      set_op(ops[i], as[i], bs[i]); #1; checks++;
      if (Result !== exp[i]) begin
        errors++; $display("FAIL arith_op%h Result=%h required %h", ops[i], Result, exp[i]);
      end
    end
  endtask

  task automatic test_shift;
    logic [5:0]  ops [5];
    logic [31:0] as  [5];
    logic [31:0] exp [5];
    ops = '{6'h0D, 6'h0C, 6'h0B, 6'h0E, 6'h10};
    as  = '{32'd0, 32'd0, 32'd0, 32'd33, 32'd4};
    exp = '{32'hF8000000, 32'h08000000, 32'd0, 32'd0, 32'hF8000000};
    for (int i = 0; i < 5; i++) begin
      set_op(ops[i], as[i], 32'h80000000); ShiftAmount = 5'd4; #1; checks++;
      if (Result !== exp[i]) begin
        errors++; $display("FAIL shift_op%h Result=%h required %h", ops[i], Result, exp[i]);
      end
    end
  endtask

  task automatic test_mult;
    @(negedge CLK); set_op(6'h12, 32'hFFFFFFFF, 32'd2); Valid = 1'b1; #1; checks++;
    if (Result !== 32'd0) begin errors++; $display("FAIL mult_result Result=%h required 0", Result); end
    @(posedge CLK); #1; checks++;
    if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFE) begin
      errors++; $display("FAIL mult HI=%h LO=%h required ffffffff/fffffffe", HI, LO);
    end
    @(negedge CLK); set_op(6'h13, 32'd3, 32'd5); Valid = 1'b0;
    @(posedge CLK); #1; checks++;
    if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFE) begin
      errors++; $display("FAIL mult_novalid HI=%h LO=%h required ffffffff/fffffffe", HI, LO);
    end
    @(negedge CLK); set_op(6'h13, 32'hFFFFFFFF, 32'd2); Valid = 1'b1;
    @(posedge CLK); #1; checks++;
    if (HI !== 32'd1 || LO !== 32'hFFFFFFFE) begin
      errors++; $display("FAIL multu HI=%h LO=%h required 00000001/fffffffe", HI, LO);
    end
  endtask

  task automatic test_div;
    @(negedge CLK); set_op(6'h14, 32'hFFFFFFF9, 32'd2); Valid = 1'b1;
    @(posedge CLK); #1; checks++;
    if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFD) begin
      errors++; $display("FAIL div HI=%h LO=%h required ffffffff/fffffffd", HI, LO);
    end
    @(negedge CLK); set_op(6'h15, 32'd7, 32'd0);
    @(posedge CLK); #1; checks++;
    if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFD) begin
      errors++; $display("FAIL divu_zero HI=%h LO=%h required ffffffff/fffffffd", HI, LO);
    end
    @(negedge CLK); set_op(6'h17, 32'd0, 32'd0); Valid = 1'b0; #1; checks++;
    if (Result !== 32'hFFFFFFFD) begin errors++; $display("FAIL mflo Result=%h required fffffffd", Result); end
    ALU_Control = 6'h16; #1; checks++;
    if (Result !== 32'hFFFFFFFF) begin errors++; $display("FAIL mfhi Result=%h required ffffffff", Result); end
    @(negedge CLK); set_op(6'h14, 32'h80000000, 32'hFFFFFFFF); Valid = 1'b1;
    @(posedge CLK); #1; checks++;
    if (HI !== 32'd0 || LO !== 32'h80000000) begin
      errors++; $display("FAIL div_ovf HI=%h LO=%h required 00000000/80000000", HI, LO);
    end
    @(negedge CLK); set_op(6'h15, 32'd7, 32'd2);
    @(posedge CLK); #1; checks++;
    if (HI !== 32'd1 || LO !== 32'd3) begin
      errors++; $display("FAIL divu HI=%h LO=%h required 00000001/00000003", HI, LO);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge CLK); set_op(6'h18, 32'h1234, 32'd0); Valid = 1'b1;
    @(posedge CLK); #1; checks++;
    if (HI !== 32'h1234) begin errors++; $display("FAIL mthi HI=%h required 00001234", HI); end
    @(negedge CLK); set_op(6'h19, 32'h55, 32'd0);
    #2 RESET = 1'b0; #1; checks++;
    if (HI !== 32'd0 || LO !== 32'd0) begin
      errors++; $display("FAIL reset_async HI=%h LO=%h required 0/0", HI, LO);
    end
    ALU_Control = 6'h1A; #1; checks++;
    if (Result !== 32'h55) begin errors++; $display("FAIL reset_comb Result=%h required 00000055", Result); end
    ALU_Control = 6'h19;
    @(posedge CLK); #1; checks++;
    if (LO !== 32'd0) begin errors++; $display("FAIL reset_hold LO=%h required 0", LO); end
    @(negedge CLK); RESET = 1'b1; Valid = 1'b0;
    @(posedge CLK); #1; checks++;
    if (HI !== 32'd0 || LO !== 32'd0) begin
      errors++; $display("FAIL reset_after HI=%h LO=%h required 0/0", HI, LO);
    end
    @(negedge CLK); Valid = 1'b1;
    @(posedge CLK); #1; checks++;
    if (LO !== 32'h55) begin errors++; $display("FAIL mtlo LO=%h required 00000055", LO); end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_arith();
    test_shift();
    test_mult();
    test_div();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
